// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, opcode width
// and the controller state encoding.
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SHR = 4'b0001;
  localparam logic [OP_W-1:0] OP_SHL = 4'b0010;
  localparam logic [OP_W-1:0] OP_NOT = 4'b0011;
  localparam logic [OP_W-1:0] OP_AND = 4'b0100;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0101;
  localparam logic [OP_W-1:0] OP_XOR = 4'b0110;
  localparam logic [OP_W-1:0] OP_CMP = 4'b0111;
  localparam logic [OP_W-1:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-and-add multiplier, one multiplier bit per clock.
// start loads the operands; WIDTH steps follow. done is high during the cycle
// in which the final step is applied, and product then carries the completed
// result (it is the combinational output of that final step). product is only
// meaningful while done is high.
module alu_mul_iter
#(
  parameter int WIDTH = 8
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH:0]     sum;
  logic [CW-1:0]      cnt;

  // One step: add the multiplicand into the high half when the current
  // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    acc_next = {sum, acc[WIDTH-1:1]};
  end

  assign done    = busy && (cnt == CW'(1));
  assign product = acc_next;

  // Operand load on start, then WIDTH accumulate/shift steps.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy  <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      mcand <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= CW'(WIDTH);
      acc   <= {{WIDTH{1'b0}}, b};
      mcand <= a;
    end else if (busy) begin
      acc <= acc_next;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides.
// Optional feature macro: ALU_MUL_EN -- when defined, opcode 1000 is an
// iterative unsigned multiply (alu_mul_iter); otherwise it is reserved and
// out_hi is tied to zero.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready = 1
// BUSY  | multiply in progress, in_ready = 0
// DONE  | result presented (out_valid = 1), held until out_ready
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             flag_a,
  output logic             flag_e,
  output logic             flag_z,
  output logic             flag_c
);

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             is_mul;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic [WIDTH:0]   add_sum;

  assign add_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};

  // Single-cycle result and carry; reserved opcodes (and MUL, which takes
  // its own path) fall through to zero.
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    case (op)
      OP_ADD: {res_c, res} = add_sum;
      OP_SHR: begin
        res   = {carry_in, b[WIDTH-1:1]};
        res_c = b[0];
      end
      OP_SHL: begin
        res   = {b[WIDTH-2:0], carry_in};
        res_c = b[WIDTH-1];
      end
      OP_NOT: res = ~a;
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_CMP: res = a ^ b;
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  assign is_mul = (op == OP_MUL);
`else
  assign is_mul = 1'b0;
`endif

  assign accept = in_valid & in_ready;

`ifdef ALU_MUL_EN
  logic                 mul_busy;
  logic                 mul_done;
  logic [2*WIDTH-1:0]   mul_product;
  logic                 mul_a;
  logic                 mul_e;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (accept & is_mul),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // A/E for a multiply come from the operands at accept time; keep them
  // aside so the visible flags only change when the product lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_a <= 1'b0;
      mul_e <= 1'b0;
    end else if (accept && is_mul) begin
      mul_a <= (a > b);
      mul_e <= (a == b);
    end
  end
`endif

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = is_mul ? BUSY : DONE;
        end
      end
      BUSY: begin
`ifdef ALU_MUL_EN
        if (mul_done) begin
          state_next = DONE;
        end else if (!mul_busy) begin
          state_next = IDLE;
        end
`else
        state_next = IDLE;
`endif
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            state_next = is_mul ? BUSY : DONE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Result/flag registers: loaded on a single-cycle accept or when the
  // multiply finishes, otherwise held.
  always_ff @(posedge clk) begin
    if (reset) begin
      out    <= '0;
      flag_a <= 1'b0;
      flag_e <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else if (accept && !is_mul) begin
      out    <= res;
      flag_a <= (a > b);
      flag_e <= (a == b);
      flag_z <= (res == '0);
      flag_c <= res_c;
    end
`ifdef ALU_MUL_EN
    else if (mul_done) begin
      out    <= mul_product[WIDTH-1:0];
      flag_a <= mul_a;
      flag_e <= mul_e;
      flag_z <= (mul_product[WIDTH-1:0] == '0);
      flag_c <= (mul_product[2*WIDTH-1:WIDTH] != '0);
    end
`endif
  end

`ifdef ALU_MUL_EN
  // High half is only ever non-zero after a multiply.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_hi <= '0;
    end else if (accept && !is_mul) begin
      out_hi <= '0;
    end else if (mul_done) begin
      out_hi <= mul_product[2*WIDTH-1:WIDTH];
    end
  end
`else
  assign out_hi = '0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vectors plus randomized traffic with random
// output back-pressure, checked by a queue-based scoreboard.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic [W-1:0] out_hi;
  logic         flag_a;
  logic         flag_e;
  logic         flag_z;
  logic         flag_c;

  int n_tests = 0;
  int n_fail  = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: never ready

  typedef struct {
    logic [W-1:0] o;
    logic [W-1:0] hi;
    logic         fa;
    logic         fe;
    logic         fz;
    logic         fc;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_hi    (out_hi),
    .flag_a    (flag_a),
    .flag_e    (flag_e),
    .flag_z    (flag_z),
    .flag_c    (flag_c)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference model written from the opcode table with plain integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                 input logic xc, input logic [3:0] xop);
    exp_t e;
    longint unsigned m  = (64'd1 << W) - 1;
    longint unsigned ua = 64'(xa);
    longint unsigned ub = 64'(xb);
    longint unsigned r  = 0;
    longint unsigned hi = 0;
    bit c = 0;
    case (xop)
      4'd0: begin r = ua + ub + 64'(xc); c = (r > m); r = r & m; end
      4'd1: begin r = (64'(xc) << (W - 1)) | (ub >> 1); c = (ub % 2) == 1; end
      4'd2: begin r = ((ub << 1) | 64'(xc)) & m; c = ((ub >> (W - 1)) & 1) == 1; end
      4'd3: r = ~ua & m;
      4'd4: r = ua & ub;
      4'd5: r = ua | ub;
      4'd6: r = ua ^ ub;
      4'd7: r = ua ^ ub;
      4'd8: begin
`ifdef ALU_MUL_EN
        r  = (ua * ub) & m;
        hi = (ua * ub) >> W;
        c  = (hi != 0);
`endif
      end
      default: r = 0;
    endcase
    e.o  = W'(r);
    e.hi = W'(hi);
    e.fa = (ua > ub);
    e.fe = (ua == ub);
    e.fz = (r == 0);
    e.fc = c;
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation, wait (bounded) for acceptance, record expectation.
  // Returns #1 after the accepting edge with in_valid dropped.
  task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb,
                      input logic xc, input logic [3:0] xop);
    int guard = 0;
    in_valid = 1'b1;
    a        = xa;
    b        = xb;
    carry_in = xc;
    op       = xop;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
    end else begin
      exp_q.push_back(model(xa, xb, xc, xop));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out"}, out, 0);
    check({tag, "_out_hi"}, out_hi, 0);
    check({tag, "_flags"}, {flag_a, flag_e, flag_z, flag_c}, 0);
  endtask

  // Output-ready driver.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard monitor: compares every completed output transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: out=0x%0h presented, no result outstanding", out);
        end else begin
          e = exp_q.pop_front();
          check("sb_out", out, e.o);
          check("sb_out_hi", out_hi, e.hi);
          check("sb_flag_a", flag_a, e.fa);
          check("sb_flag_e", flag_e, e.fe);
          check("sb_flag_z", flag_z, e.fz);
          check("sb_flag_c", flag_c, e.fc);
        end
      end
    end
  end

  initial begin
    int stale;
    int guard;
    exp_t dropped;
    reset    = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    carry_in = 1'b0;
    op       = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_cleared("reset");
    tick();

    // ADD with carry out and zero result, one-cycle latency.
    send(8'hFF, 8'h01, 1'b0, 4'b0000);
    @(negedge clk);
    check("add_latency", out_valid, 1);
    check("add_out", out, 8'h00);
    check("add_c", flag_c, 1);
    check("add_z", flag_z, 1);
    check("add_a", flag_a, 1);
    check("add_e", flag_e, 0);
    tick();

    send(8'h00, 8'h81, 1'b1, 4'b0001);
    @(negedge clk);
    check("shr_out", out, 8'hC0);
    check("shr_c", flag_c, 1);
    tick();

    send(8'h00, 8'h81, 1'b0, 4'b0010);
    @(negedge clk);
    check("shl_out", out, 8'h02);
    check("shl_c", flag_c, 1);
    tick();

    send(8'h5A, 8'h5A, 1'b0, 4'b0111);
    @(negedge clk);
    check("cmp_eq_out", out, 8'h00);
    check("cmp_eq_zea", {flag_z, flag_e, flag_a}, 3'b110);
    tick();

    send(8'h10, 8'h20, 1'b0, 4'b0111);
    @(negedge clk);
    check("cmp_ne_zea", {flag_z, flag_e, flag_a}, 3'b000);
    tick();

`ifdef ALU_MUL_EN
    send(8'hFF, 8'hFF, 1'b0, 4'b1000);
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      check("mul_busy_valid", out_valid, 0);
      check("mul_busy_in_ready", in_ready, 0);
    end
    @(negedge clk);
    check("mul_latency", out_valid, 1);
    check("mul_out_hi", out_hi, 8'hFE);
    check("mul_out", out, 8'h01);
    check("mul_c", flag_c, 1);
    tick();

    send(8'h00, 8'hA5, 1'b0, 4'b1000);
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("mul_zero_valid", out_valid, 1);
    check("mul_zero_zc", {flag_z, flag_c}, 2'b10);
    tick();
`else
    send(8'h12, 8'h34, 1'b1, 4'b1000);
    @(negedge clk);
    check("rsv8_latency", out_valid, 1);
    check("rsv8_out", {out_hi, out}, 0);
    check("rsv8_zc", {flag_z, flag_c}, 2'b10);
    tick();
`endif

    // Back-pressure: result held, in_ready low, then back-to-back accept.
    ready_mode = 2;
    tick();
    send(8'h0F, 8'h33, 1'b0, 4'b0110);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_out", out, 8'h3C);
    end
    ready_mode = 0;
    send(8'hF0, 8'h3C, 1'b0, 4'b0100);
    @(negedge clk);
    check("bp_next_valid", out_valid, 1);
    check("bp_next_out", out, 8'h30);
    tick();

    // Reset while a result is waiting in DONE.
    ready_mode = 2;
    tick();
    send(8'h0F, 8'hF0, 1'b0, 4'b0110);
    @(negedge clk);
    check("rst_done_pre_valid", out_valid, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    dropped = exp_q.pop_back();
    @(negedge clk);
    check_cleared("rst_done");
    ready_mode = 0;
    tick();

`ifdef ALU_MUL_EN
    // Reset in the third BUSY cycle abandons the multiply.
    send(8'hC3, 8'h5A, 1'b0, 4'b1000);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    dropped = exp_q.pop_back();
    @(negedge clk);
    check_cleared("rst_mul");
    stale = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("rst_mul_no_stale", stale, 0);
    tick();
`endif

    // Randomized traffic with random back-pressure and idle gaps.
    ready_mode = 1;
    tick();
    for (int n = 0; n < 300; n++) begin
      logic [3:0] rop;
      if ($urandom_range(0, 4) == 0) rop = 4'($urandom_range(9, 15));
      else                           rop = 4'($urandom_range(0, 8));
      send(rnd_val(), rnd_val(), 1'($urandom_range(0, 1)), rop);
      if ($urandom_range(0, 3) == 0) tick();
    end

    ready_mode = 0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_out_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the 8-bit combinational ALU.
- Operands are accepted through a valid/ready input handshake; result and flags are returned through a valid/ready output handshake.
- Keeps the eight existing operations with their encodings. Adds an iterative unsigned multiply.
- Sits between the register file and the accumulator/flag register of the mini computer datapath.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 4..32.

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  a, b, carry_in, op are valid this cycle
in_ready  output  1  block can accept an operation this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
carry_in  input  1  carry/shift-in bit
op  input  4  opcode; see Behaviour
out_valid  output  1  out, out_hi and flags are valid
out_ready  input  1  consumer accepts the result this cycle
out  output  WIDTH  result, low half for MUL
out_hi  output  WIDTH  MUL high half; 0 for every other op
flag_a  output  1  a > b, unsigned
flag_e  output  1  a == b
flag_z  output  1  out == 0
flag_c  output  1  carry/overflow, per op

Behaviour:
- Reset (sync, dominant over all inputs):
  - state = IDLE.
  - out, out_hi and all flags = 0.
  - out_valid = 0; in_ready = 1 in the cycle after reset deasserts.
  - Reset during BUSY abandons the multiply; no result is produced.
- Transfer rules: input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
- Opcodes and results. Operands are latched on input transfer.
  - 0000 ADD: out = a + b + carry_in; C = carry out of the MSB.
  - 0001 SHR: out = {carry_in, b[WIDTH-1:1]}; C = b[0].
  - 0010 SHL: out = {b[WIDTH-2:0], carry_in}; C = b[WIDTH-1].
  - 0011 NOT: out = ~a; C = 0.
  - 0100 AND, 0101 OR, 0110 XOR: bitwise; C = 0.
  - 0111 CMP: out = a ^ b, so Z = 1 iff equal; C = 0.
  - 1000 MUL: {out_hi, out} = a * b, unsigned; C = (out_hi != 0). Only when ALU_MUL_EN is defined.
  - All other opcodes (reserved): out = 0, C = 0, Z = 1.
- Flags:
  - A and E are computed from a and b for every op, including reserved ones.
  - Z always reflects out only; out_hi does not affect Z.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready = 1. On input transfer, a single-cycle op goes to DONE and MUL goes to BUSY.
  - BUSY: in_ready = 0. Shift-and-add runs one bit per cycle for WIDTH cycles, then goes to DONE.
  - DONE: out_valid = 1; outputs are held stable until the output transfer.
    - in_ready = out_ready, so back-to-back accept is allowed.
    - Output transfer with no new input goes to IDLE.
    - Output transfer with a simultaneous input transfer goes to DONE (single-cycle op) or BUSY (MUL).
- Latency from the input transfer cycle N:
  - Single-cycle ops: out_valid at N+1.
  - MUL: out_valid at N+1+WIDTH.
- Throughput: one single-cycle op per clock while out_ready is held high.
- Holding rules:
  - in_valid while in_ready = 0 is ignored; the source must hold its values.
  - Outputs change only on an input-transfer completion or on reset.
- MUL corner cases:
  - a = 0 or b = 0 gives 0, Z = 1, C = 0.
  - Full-scale operands: (2^W-1)^2 gives out_hi = 2^W-2, out = 1.

Optional Feature:
ALU_MUL_EN
- Defined: opcode 1000 is MUL as above; the BUSY state and the multiplier are present.
- Undefined: 1000 is reserved (out = 0, Z = 1, C = 0, one-cycle latency); out_hi is tied to 0; BUSY is never entered.

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams OP_ADD..OP_MUL.
  - OP_W = 4.
  - State encoding IDLE/BUSY/DONE.
- One sub-module: alu_mul_iter, the iterative shift-and-add multiplier.
  - Ports: clk, reset, start, a, b, busy, done, product[2*WIDTH-1:0].
  - Instantiated only under ALU_MUL_EN.

Test Plan:
- WIDTH=8, ADD a=0xFF b=0x01 cin=0 -> out=0x00, C=1, Z=1, A=1, E=0, out_valid at N+1.
- SHR b=0x81 cin=1 -> out=0xC0, C=1; SHL b=0x81 cin=0 -> out=0x02, C=1.
- CMP a=b=0x5A -> out=0x00, Z=1, E=1, A=0; CMP a=0x10 b=0x20 -> A=0, E=0, Z=0.
- MUL (ALU_MUL_EN) a=0xFF b=0xFF -> out_hi=0xFE, out=0x01, C=1, out_valid at N+9, in_ready=0 throughout BUSY.
- Back-pressure: hold out_ready=0 for 5 cycles after DONE -> outputs stable, in_ready=0. Then out_ready=1 with in_valid=1 (AND 0xF0, 0x3C) -> next out=0x30 one cycle later.
- Reset asserted mid-MUL at BUSY cycle 3 -> next cycle: out_valid=0, all outputs 0, in_ready=1. No stale result ever appears.
